// File: rtl/bus_master_port.sv
// Serial bus master port: wins the bus, shifts address and write data out LSB first, collects read data.
// Define BUS_TIMEOUT_EN to abort transactions that stall for TIMEOUT consecutive cycles.
module bus_master_port #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 12,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  bus_req,
  input  logic                  bus_grant,
  output logic                  bus_mode,
  output logic                  bus_out,
  output logic                  bus_out_valid,
  input  logic                  bus_in,
  input  logic                  bus_in_valid,
  input  logic                  slave_ready
);
  // state    | meaning
  // IDLE     | waiting for a command, cmd_ready high
  // REQ      | bus requested, waiting for grant
  // ADDR     | shifting address out
  // WAIT_SLV | waiting for slave to decode the address
  // WDATA    | shifting write data out
  // RDATA    | collecting read data bits
  // DONE     | one-cycle response pulse
  typedef enum logic [2:0] {IDLE, REQ, ADDR, WAIT_SLV, WDATA, RDATA, DONE} state_t;

  localparam int MAX_W = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CNT_W = $clog2(MAX_W + 1);

  if (TIMEOUT < 1) begin : g_timeout_check
    $error("TIMEOUT must be at least 1");
  end

  state_t                state;
  logic                  wr_q;
  logic [ADDR_WIDTH-1:0] addr_sh;
  logic [DATA_WIDTH-1:0] data_sh;
  logic [CNT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] rd_next;
  logic                  grant_lost;
  logic                  stall_expired;

  assign rd_next    = {bus_in, data_sh[DATA_WIDTH-1:1]};
  assign grant_lost = !bus_grant && (state inside {ADDR, WAIT_SLV, WDATA, RDATA});

`ifdef BUS_TIMEOUT_EN
  localparam int STALL_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [STALL_W-1:0] stall_left;
  logic               stalled;

  assign stalled = (state == REQ && !bus_grant) ||
                   (state == WAIT_SLV && !slave_ready) ||
                   (state == RDATA && !bus_in_valid);
  assign stall_expired = stalled && (stall_left == '0);

  // Reloaded on every non-stall cycle, so each stall run starts from a full budget.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_left <= '0;
    end else if (!stalled) begin
      stall_left <= STALL_W'(TIMEOUT - 1);
    end else if (stall_left != '0) begin
      stall_left <= stall_left - STALL_W'(1);
    end
  end
`else
  assign stall_expired = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      wr_q          <= 1'b0;
      addr_sh       <= '0;
      data_sh       <= '0;
      bit_cnt       <= '0;
      cmd_ready     <= 1'b1;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_err       <= 1'b0;
      bus_req       <= 1'b0;
      bus_mode      <= 1'b0;
      bus_out       <= 1'b0;
      bus_out_valid <= 1'b0;
    end else if (grant_lost || stall_expired) begin
      // Abort wins over any progress in the same cycle, including the last shift bit.
      state         <= DONE;
      rsp_valid     <= 1'b1;
      rsp_err       <= 1'b1;
      bus_req       <= 1'b0;
      bus_mode      <= 1'b0;
      bus_out       <= 1'b0;
      bus_out_valid <= 1'b0;
      bit_cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            wr_q      <= cmd_write;
            addr_sh   <= cmd_addr;
            data_sh   <= cmd_wdata;
            cmd_ready <= 1'b0;
            bus_req   <= 1'b1;
            state     <= REQ;
          end
        end
        REQ: begin
          if (bus_grant) begin
            state         <= ADDR;
            bus_mode      <= wr_q;
            bus_out       <= addr_sh[0];
            bus_out_valid <= 1'b1;
            addr_sh       <= addr_sh >> 1;
            bit_cnt       <= CNT_W'(1);
          end
        end
        ADDR: begin
          if (bit_cnt == CNT_W'(ADDR_WIDTH)) begin
            state         <= WAIT_SLV;
            bus_out       <= 1'b0;
            bus_out_valid <= 1'b0;
            bit_cnt       <= '0;
          end else begin
            bus_out <= addr_sh[0];
            addr_sh <= addr_sh >> 1;
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
        WAIT_SLV: begin
          if (slave_ready) begin
            if (wr_q) begin
              state         <= WDATA;
              bus_out       <= data_sh[0];
              bus_out_valid <= 1'b1;
              data_sh       <= data_sh >> 1;
              bit_cnt       <= CNT_W'(1);
            end else begin
              state   <= RDATA;
              bit_cnt <= '0;
            end
          end
        end
        WDATA: begin
          if (bit_cnt == CNT_W'(DATA_WIDTH)) begin
            state         <= DONE;
            rsp_valid     <= 1'b1;
            rsp_err       <= 1'b0;
            bus_req       <= 1'b0;
            bus_mode      <= 1'b0;
            bus_out       <= 1'b0;
            bus_out_valid <= 1'b0;
            bit_cnt       <= '0;
          end else begin
            bus_out <= data_sh[0];
            data_sh <= data_sh >> 1;
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
        RDATA: begin
          if (bus_in_valid) begin
            data_sh <= rd_next;
            if (bit_cnt == CNT_W'(DATA_WIDTH - 1)) begin
              state     <= DONE;
              rsp_rdata <= rd_next;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b0;
              bus_req   <= 1'b0;
              bus_mode  <= 1'b0;
              bit_cnt   <= '0;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
        end
        DONE: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          cmd_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bus_master_port.sv
// Directed bench for bus_master_port: transaction vector table plus abort, reset and stall sequences.
module tb_bus_master_port;
  localparam int DW = 8;
  localparam int AW = 12;
  localparam int TO = 255;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          bus_req;
  logic          bus_grant = 1'b1;
  logic          bus_mode;
  logic          bus_out;
  logic          bus_out_valid;
  logic          bus_in = 1'b0;
  logic          bus_in_valid = 1'b0;
  logic          slave_ready = 1'b1;

  always #5 clk = ~clk;

  bus_master_port #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .bus_req(bus_req), .bus_grant(bus_grant), .bus_mode(bus_mode),
    .bus_out(bus_out), .bus_out_valid(bus_out_valid),
    .bus_in(bus_in), .bus_in_valid(bus_in_valid), .slave_ready(slave_ready)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Outputs packed as {cmd_ready, rsp_valid, rsp_err, bus_req, bus_mode, bus_out, bus_out_valid}
  function automatic logic [6:0] out_vec();
    return {cmd_ready, rsp_valid, rsp_err, bus_req, bus_mode, bus_out, bus_out_valid};
  endfunction

  // Presents a command and returns at the sampling point of cycle 1 (first cycle after accept).
  task automatic start_cmd(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Runs one transaction, acting as slave for reads; cycle 1 is the first cycle after the accept edge.
  task automatic do_txn(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                        input logic [DW-1:0] sd, input bit gap, input int gdelay, input int inject,
                        output int lat, output logic [19:0] stream, output int nbits,
                        output int viol, output logic err, output logic [DW-1:0] rdata);
    int addr_done;
    int rd_idx;
    int d;
    lat = -1; stream = '0; nbits = 0; viol = 0; err = 1'b0; rdata = '0;
    addr_done = -1; rd_idx = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd;
    bus_grant = (gdelay == 0);
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int cyc = 1; cyc <= 2000; cyc++) begin
      if (cyc > 1) @(negedge clk);
      bus_grant = (cyc > gdelay);
      cmd_valid = (cyc == inject);
      if (cyc == inject) begin
        cmd_addr = ~addr; cmd_wdata = ~wd; cmd_write = ~wr;
      end
      if (cmd_ready !== 1'b0) viol++;
      if (rsp_valid === 1'b1) begin
        lat = cyc; err = rsp_err; rdata = rsp_rdata;
        if (bus_req !== 1'b0 || bus_mode !== 1'b0 || bus_out_valid !== 1'b0) viol++;
        break;
      end
      if (bus_req !== 1'b1) viol++;
      if (bus_out_valid === 1'b1) begin
        if (nbits < 20) stream[nbits] = bus_out;
        nbits++;
        if (bus_mode !== wr) viol++;
        if (nbits == AW) addr_done = cyc;
      end else if (bus_out !== 1'b0) begin
        viol++;
      end
      bus_in_valid = 1'b0; bus_in = 1'b0;
      if (!wr && addr_done > 0 && cyc >= addr_done + 2 && rd_idx < DW) begin
        d = cyc - (addr_done + 2);
        if (!gap || (d % 2) == 1) begin
          bus_in_valid = 1'b1; bus_in = sd[rd_idx]; rd_idx++;
        end
      end
    end
    cmd_valid = 1'b0; bus_in_valid = 1'b0; bus_grant = 1'b1;
    @(negedge clk);
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || rsp_err !== 1'b0) viol++;
  endtask

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] sdata;
    bit            gap;
    int            gdelay;
    int            exp_lat;
    logic [19:0]   exp_stream;
    int            exp_nbits;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  localparam int NV = 6;
  vec_t vecs[NV];

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog expired before the end of the test");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int            lat, nbits, viol, cnt;
    logic [19:0]   stream;
    logic          err;
    logic [DW-1:0] rdata;

    vecs[0] = '{1'b1, 12'hA5C, 8'hAA, 8'h00, 1'b0, 0, 23, 20'hAAA5C, 20, 8'h00};
    vecs[1] = '{1'b0, 12'h003, 8'h00, 8'h5A, 1'b1, 0, 31, 20'h00003, 12, 8'h5A};
    vecs[2] = '{1'b1, 12'h3FF, 8'h81, 8'h00, 1'b0, 0, 23, 20'h813FF, 20, 8'h5A};
    vecs[3] = '{1'b0, 12'h800, 8'h00, 8'hC3, 1'b0, 2, 25, 20'h00800, 12, 8'hC3};
    vecs[4] = '{1'b1, 12'h5A5, 8'h3C, 8'h00, 1'b0, 3, 26, 20'h3C5A5, 20, 8'hC3};
    vecs[5] = '{1'b0, 12'hFFF, 8'h00, 8'h81, 1'b0, 0, 23, 20'h00FFF, 12, 8'h81};

    #12;
    chk("reset_outputs", out_vec(), 7'b1000000);
    chk("reset_rdata", rsp_rdata, 8'h00);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < NV; i++) begin
      do_txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].sdata, vecs[i].gap,
             vecs[i].gdelay, 0, lat, stream, nbits, viol, err, rdata);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      chk($sformatf("v%0d_stream", i), stream, vecs[i].exp_stream);
      chk($sformatf("v%0d_nbits", i), nbits, vecs[i].exp_nbits);
      chk($sformatf("v%0d_err", i), err, 1'b0);
      chk($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rdata);
      chk($sformatf("v%0d_protocol", i), viol, 0);
    end

    // Grant dropped while the 4th address bit is on the bus
    start_cmd(1'b1, 12'h128, 8'h55);
    repeat (4) @(negedge clk);
    chk("drop_bit4_valid", bus_out_valid, 1'b1);
    chk("drop_bit4_value", bus_out, 1'b1);
    bus_grant = 1'b0;
    @(negedge clk);
    chk("drop_rsp", {rsp_valid, rsp_err, bus_req, bus_out_valid}, 4'b1100);
    chk("drop_rdata_hold", rsp_rdata, 8'h81);
    bus_grant = 1'b1;
    @(negedge clk);
    chk("drop_back_idle", {cmd_ready, rsp_valid, rsp_err}, 3'b100);
    do_txn(1'b1, 12'h0F0, 8'h5A, 8'h00, 1'b0, 0, 0, lat, stream, nbits, viol, err, rdata);
    chk("after_drop_latency", lat, 23);
    chk("after_drop_stream", stream, 20'h5A0F0);
    chk("after_drop_err", err, 1'b0);

    // Grant dropped during the final write data bit still aborts
    start_cmd(1'b1, 12'hABC, 8'hFF);
    repeat (21) @(negedge clk);
    chk("lastbit_valid", {bus_out_valid, bus_out}, 2'b11);
    bus_grant = 1'b0;
    @(negedge clk);
    chk("lastbit_abort", {rsp_valid, rsp_err}, 2'b11);
    bus_grant = 1'b1;
    @(negedge clk);

    // Reset during WDATA bit 3
    start_cmd(1'b1, 12'h456, 8'h0F);
    repeat (17) @(negedge clk);
    chk("wdata_bit3", {bus_out_valid, bus_out}, 2'b11);
    reset = 1'b0;
    #1;
    chk("midreset_outputs", out_vec(), 7'b1000000);
    chk("midreset_rdata", rsp_rdata, 8'h00);
    @(negedge clk);
    reset = 1'b1;
    cnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || bus_req !== 1'b0) cnt++;
    end
    chk("midreset_quiet", cnt, 0);
    do_txn(1'b1, 12'h456, 8'h0F, 8'h00, 1'b0, 0, 0, lat, stream, nbits, viol, err, rdata);
    chk("after_reset_latency", lat, 23);
    chk("after_reset_stream", stream, 20'h0F456);
    chk("after_reset_protocol", viol, 0);

    // Command pulsed during ADDR is ignored
    do_txn(1'b1, 12'h9C3, 8'hE7, 8'h00, 1'b0, 0, 4, lat, stream, nbits, viol, err, rdata);
    chk("inject_latency", lat, 23);
    chk("inject_stream", stream, 20'hE79C3);
    chk("inject_protocol", viol, 0);
    cnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus_req !== 1'b0 || bus_out_valid !== 1'b0 || rsp_valid !== 1'b0) cnt++;
    end
    chk("inject_no_second_txn", cnt, 0);

    // Read with slave_ready held low
    slave_ready = 1'b0;
    start_cmd(1'b0, 12'h003, 8'h00);
`ifdef BUS_TIMEOUT_EN
    lat = -1; err = 1'b0;
    for (int cyc = 1; cyc <= 1000; cyc++) begin
      if (cyc > 1) @(negedge clk);
      if (rsp_valid === 1'b1) begin
        lat = cyc; err = rsp_err;
        break;
      end
    end
    chk("timeout_latency", lat, 269);
    chk("timeout_err", err, 1'b1);
`else
    cnt = 0;
    for (int cyc = 1; cyc <= 1000; cyc++) begin
      if (cyc > 1) @(negedge clk);
      if (rsp_valid !== 1'b0) cnt++;
    end
    chk("no_timeout_rsp", cnt, 0);
    chk("stall_bus_req", bus_req, 1'b1);
    bus_grant = 1'b0;
    @(negedge clk);
    chk("stall_abort", {rsp_valid, rsp_err}, 2'b11);
`endif
    slave_ready = 1'b1;
    bus_grant = 1'b1;
    @(negedge clk);
    chk("final_idle", {cmd_ready, rsp_valid, bus_req}, 3'b100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
